// File: rtl/register_file_legv8.sv
// LEGv8 architectural register file: 32 x 64-bit registers with XZR hard-wired to zero,
// same-cycle write-to-read bypass on both read ports, and a separately enabled NZCV flag register.
module register_file_legv8 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] SA,
    input  logic [ADDR_WIDTH-1:0] SB,
    input  logic [ADDR_WIDTH-1:0] DA,
    input  logic                  W,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            status_in,
    input  logic                  FL,
    output logic [3:0]            status
);

    localparam int                  NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam logic                BYPASS_EN = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  write_en;
    logic                  fwd_ok;

    assign write_en = W && (DA != ZERO_ADDR);
    // A write being dropped by reset must not be forwarded either.
    assign fwd_ok   = BYPASS_EN && W && !reset;

    // Storage and flags; reset wins over any write presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            status <= 4'b0000;
        end else begin
            if (write_en) begin
                regs[DA] <= D;
            end
            if (FL) begin
                status <= status_in;
            end
        end
    end

    // Read ports: XZR beats the bypass path, which beats the stored value.
    always_comb begin
        A = regs[SA];
        B = regs[SB];
        if (SA == ZERO_ADDR) begin
            A = '0;
        end else if (fwd_ok && (DA == SA)) begin
            A = D;
        end
        if (SB == ZERO_ADDR) begin
            B = '0;
        end else if (fwd_ok && (DA == SB)) begin
            B = D;
        end
    end

endmodule

// File: tb/tb_register_file_legv8.sv
// Self-checking bench: a bypassing and a non-bypassing instance share one set of inputs and
// are compared every cycle against an array model, plus hand-computed spot checks.
module tb_register_file_legv8;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  sa, sb, da;
    logic        w;
    logic [63:0] d;
    logic [3:0]  status_in;
    logic        fl;
    logic [63:0] a_byp, b_byp, a_nob, b_nob;
    logic [3:0]  status_byp, status_nob;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model_regs [32];
    logic [3:0]  model_status;
    bit          model_valid = 1'b0;

    always #5 clock = ~clock;

    register_file_legv8 #(.BYPASS(1)) u_dut_byp (
        .clock(clock), .reset(reset), .SA(sa), .SB(sb), .DA(da), .W(w), .D(d),
        .A(a_byp), .B(b_byp), .status_in(status_in), .FL(fl), .status(status_byp)
    );

    register_file_legv8 #(.BYPASS(0)) u_dut_nob (
        .clock(clock), .reset(reset), .SA(sa), .SB(sb), .DA(da), .W(w), .D(d),
        .A(a_nob), .B(b_nob), .status_in(status_in), .FL(fl), .status(status_nob)
    );

    // Architectural state as the ISA sees it.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
            model_status = 4'b0000;
            model_valid  = 1'b1;
        end else begin
            if (w && da != 5'd31) model_regs[da] = d;
            if (fl) model_status = status_in;
        end
    end

    function automatic logic [63:0] expRead(input logic [4:0] addr, input bit bypass);
        if (addr == 5'd31) return 64'd0;
        if (bypass && w && !reset && da == addr) return d;
        return model_regs[addr];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model once reset has established known state.
    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("model_a_byp", a_byp, expRead(sa, 1'b1));
            checkOutput("model_b_byp", b_byp, expRead(sb, 1'b1));
            checkOutput("model_a_nob", a_nob, expRead(sa, 1'b0));
            checkOutput("model_b_nob", b_nob, expRead(sb, 1'b0));
            checkOutput("model_status_byp", {60'd0, status_byp}, {60'd0, model_status});
            checkOutput("model_status_nob", {60'd0, status_nob}, {60'd0, model_status});
        end
    end

    task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                                 input logic fe, input logic [3:0] st);
        @(posedge clock);
        #1;
        reset = rst; w = wr; da = wa; d = wd; sa = ra; sb = rb; fl = fe; status_in = st;
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_vec_t;

    wr_vec_t wr_table [6];

    initial begin
        reset = 1'b1; w = 1'b0; da = '0; d = '0; sa = '0; sb = '0; fl = 1'b0; status_in = '0;
        wr_table[0] = '{5'd0,  64'h0000_0000_0000_0001};
        wr_table[1] = '{5'd1,  64'hFFFF_FFFF_FFFF_FFFF};
        wr_table[2] = '{5'd12, 64'h8000_0000_0000_0000};
        wr_table[3] = '{5'd30, 64'hA5A5_5A5A_0F0F_F0F0};
        wr_table[4] = '{5'd16, 64'h0000_0000_CAFE_BABE};
        wr_table[5] = '{5'd12, 64'h1234_0000_0000_4321};

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        checkOutput("reset_status", {60'd0, status_byp}, 64'd0);

        // Reset after preloading X5 and flags
        applyStimulus(0, 1, 5, 64'hDEAD, 0, 0, 1, 4'b0110);
        applyStimulus(0, 0, 0, 0, 5, 5, 0, 4'b0000);
        @(negedge clock);
        checkOutput("preload_x5", a_byp, 64'hDEAD);
        checkOutput("preload_status", {60'd0, status_byp}, 64'h6);
        applyStimulus(1, 0, 0, 0, 5, 5, 0, 4'b0000);
        applyStimulus(0, 0, 0, 0, 5, 5, 0, 4'b0000);
        @(negedge clock);
        checkOutput("reset_x5", a_byp, 64'd0);
        checkOutput("reset_flags", {60'd0, status_byp}, 64'd0);

        // Plain write then read
        applyStimulus(0, 1, 3, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 4'b0000);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, 4'b0000);
        @(negedge clock);
        checkOutput("write_read_x3", a_byp, 64'h0123_4567_89AB_CDEF);

        // Bypass on both ports vs. old value without bypass
        applyStimulus(0, 1, 7, 64'd1, 0, 0, 0, 4'b0000);
        applyStimulus(0, 1, 7, 64'h55, 7, 7, 0, 4'b0000);
        @(negedge clock);
        checkOutput("bypass_a", a_byp, 64'h55);
        checkOutput("bypass_b", b_byp, 64'h55);
        checkOutput("nobypass_a_old", a_nob, 64'd1);
        checkOutput("nobypass_b_old", b_nob, 64'd1);
        applyStimulus(0, 0, 0, 0, 7, 7, 0, 4'b0000);
        @(negedge clock);
        checkOutput("nobypass_a_new", a_nob, 64'h55);

        // XZR ignores writes and always reads zero, even with a write to it in flight
        applyStimulus(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 0, 4'b0000);
        @(negedge clock);
        checkOutput("xzr_same_cycle", a_byp, 64'd0);
        applyStimulus(0, 0, 0, 0, 31, 31, 0, 4'b0000);
        @(negedge clock);
        checkOutput("xzr_next_cycle", b_byp, 64'd0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 4'b0000);
        end
        @(negedge clock);
        checkOutput("scan_x31_vs_x0", b_byp, 64'd0);

        // Reset beats a simultaneous register write and flag write
        applyStimulus(1, 1, 9, 64'hFF, 9, 9, 1, 4'b1010);
        applyStimulus(0, 0, 0, 0, 9, 3, 0, 4'b0000);
        @(negedge clock);
        checkOutput("reset_drops_x9", a_byp, 64'd0);
        checkOutput("reset_drops_x3", b_byp, 64'd0);
        checkOutput("reset_drops_flags", {60'd0, status_byp}, 64'd0);

        // Flags: capture, not bypassed, then hold
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'b0101);
        @(negedge clock);
        checkOutput("flags_not_bypassed", {60'd0, status_byp}, 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b1111);
        @(negedge clock);
        checkOutput("flags_captured", {60'd0, status_byp}, 64'h5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b1111);
        @(negedge clock);
        checkOutput("flags_hold", {60'd0, status_nob}, 64'h5);

        // Register and flag writes in the same cycle, then a table of writes/reads
        applyStimulus(0, 1, 20, 64'h7777, 20, 19, 1, 4'b1001);
        applyStimulus(0, 0, 0, 0, 20, 20, 0, 4'b0000);
        @(negedge clock);
        checkOutput("dual_update_x20", a_nob, 64'h7777);
        checkOutput("dual_update_flags", {60'd0, status_byp}, 64'h9);
        foreach (wr_table[i]) begin
            applyStimulus(0, 1, wr_table[i].addr, wr_table[i].data,
                          wr_table[i].addr, 5'(wr_table[i].addr + 5'd1), 0, 4'b0000);
        end
        for (int i = 0; i < 32; i += 3) begin
            applyStimulus(0, 0, 0, 0, 5'(i), 5'(i), 0, 4'b0000);
        end
        applyStimulus(0, 0, 0, 0, 12, 1, 0, 4'b0000);
        @(negedge clock);
        checkOutput("table_x12_overwrite", a_byp, 64'h1234_0000_0000_4321);
        checkOutput("table_x1", b_nob, 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
